// File: rtl/core_pkg.sv
// Shared core package: pipeline bundles between EX, MEM and WB, plus MEM-stage FSM encodings.
package core_pkg;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_REQ    = 2'b01;
  localparam logic [1:0] ST_RDWAIT = 2'b10;

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] writedata;
    logic [31:0] pcplus4;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memwrite;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic [31:0] aluresult;
    logic [31:0] pcplus4;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
  } mem_wb_t;

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-memory request sequencer (IDLE/REQ/RDWAIT). Optional bus timeout under MEM_STAGE_TIMEOUT_EN.
module dmem_req_fsm
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_load,
  input  logic       gnt,
  input  logic       rvalid,
  output logic       req,
  output logic       done,
  output logic       load_data,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       granted;

  // Handshake: a request is accepted in any cycle where req and gnt are both high;
  // read data is taken on rvalid only in RDWAIT or in the very cycle of the grant.
  assign req       = ((state == ST_IDLE) && start) || (state == ST_REQ);
  assign granted   = req && gnt;
  assign load_data = (granted && is_load && rvalid) || ((state == ST_RDWAIT) && rvalid);
  assign done      = (granted && !is_load) || load_data || timeout;
  assign state_dbg = state;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign timeout = (state != ST_IDLE) && (cnt == CW'(TIMEOUT_CYCLES - 1)) && !granted && !load_data;

  always_ff @(posedge clk) begin
    if (rst || (state == ST_IDLE) || (state_next == ST_IDLE)) cnt <= '0;
    else                                                      cnt <= cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (granted) state_next = (is_load && !rvalid) ? ST_RDWAIT : ST_IDLE;
          else         state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (timeout)      state_next = ST_IDLE;
        else if (granted) state_next = (is_load && !rvalid) ? ST_RDWAIT : ST_IDLE;
      end
      ST_RDWAIT: begin
        if (rvalid || timeout) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores, stalls upstream until done, registers the WB bundle.
// Optional bus timeout enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_t     in,
  input  logic        in_valid,
  output logic        stall,
  output mem_wb_t     out,
  output logic        out_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  logic       is_load;
  logic       is_mem;
  logic       mis;
  logic       mem_go;
  logic       mem_done;
  logic       load_data;
  logic       timeout;
  logic       complete;
  logic [1:0] fsm_state;

  assign is_load = (in.resultsrc == RESULTSRC_LOAD);
  assign is_mem  = is_load || in.memwrite;
  assign mis     = in_valid && is_mem && (in.aluresult[1:0] != 2'b00);
  assign mem_go  = in_valid && is_mem && !mis;

  dmem_req_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (mem_go),
    .is_load   (is_load),
    .gnt       (dmem_gnt),
    .rvalid    (dmem_rvalid),
    .req       (dmem_req),
    .done      (mem_done),
    .load_data (load_data),
    .timeout   (timeout),
    .state_dbg (fsm_state)
  );

  // Upstream holds `in` stable while stalled, so the bus fields are driven straight from it.
  assign dmem_we    = dmem_req && in.memwrite;
  assign dmem_addr  = {in.aluresult[31:2], 2'b00};
  assign dmem_wdata = in.writedata;

  assign stall    = mem_go && !mem_done;
  assign complete = (in_valid && (!is_mem || mis)) || (mem_go && mem_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      out_valid <= complete;
      misalign  <= mis;
      bus_err   <= timeout;
      if (complete) begin
        out.aluresult <= in.aluresult;
        out.pcplus4   <= in.pcplus4;
        out.rd        <= in.rd;
        out.resultsrc <= in.resultsrc;
        out.regwrite  <= in.regwrite && !mis && !timeout;
        out.readdata  <= load_data ? dmem_rdata : 32'h0;
      end
    end
  end

endmodule
